// File: rtl/height_history_ctrl_if.sv
// Sample handshake between the height sensor front end and height_history_ctrl.
// The sensor side drives valid/data; the controller answers with ready.
interface height_history_ctrl_if;
    logic       meas_valid;
    logic [7:0] meas_data;
    logic       meas_ready;

    modport master (
        output meas_valid,
        output meas_data,
        input  meas_ready
    );

    modport slave (
        input  meas_valid,
        input  meas_data,
        output meas_ready
    );
endinterface

// File: rtl/height_history_ctrl.sv
// Averages 2^AVG_LOG2 sensor samples, clamps the result and commits it into a ten-entry
// history on frame_start. Optional macro HIST_DEDUP_EN suppresses repeated commits.
module height_history_ctrl #(
    parameter int AVG_LOG2   = 2,
    parameter int MAX_INCHES = 107,
    parameter int MIN_INCHES = 0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    height_history_ctrl_if.slave        meas,
    input  logic                        frame_start,
    input  logic                        clear,
    output logic [7:0]                  hist_0,
    output logic [7:0]                  hist_1,
    output logic [7:0]                  hist_2,
    output logic [7:0]                  hist_3,
    output logic [7:0]                  hist_4,
    output logic [7:0]                  hist_5,
    output logic [7:0]                  hist_6,
    output logic [7:0]                  hist_7,
    output logic [7:0]                  hist_8,
    output logic [7:0]                  hist_9,
    output logic [3:0]                  entry_count,
`ifdef HIST_DEDUP_EN
    output logic                        dup_drop,
`endif
    output logic                        pending
);

    localparam int AW    = 8 + AVG_LOG2;
    localparam int CW    = AVG_LOG2 + 1;
    localparam int N     = 1 << AVG_LOG2;
    localparam int DEPTH = 10;

    localparam logic [CW-1:0]      LAST_CNT = CW'(N - 1);
    localparam logic signed [9:0]  MAX_S    = 10'(MAX_INCHES);
    localparam logic signed [9:0]  MIN_S    = 10'(MIN_INCHES);

    typedef enum logic [1:0] {
        ACCUM,
        DIVIDE,
        WAIT_FRAME
    } state_t;

    state_t          state_reg;
    state_t          state_next;

    logic [AW-1:0]   acc_reg;
    logic [CW-1:0]   cnt_reg;
    logic [7:0]      avg_reg;
    logic [7:0]      hist_reg [DEPTH];
    logic [3:0]      entry_count_reg;
    logic            pending_reg;
    logic            clear_pend_reg;
    logic            ready_en_reg;
`ifdef HIST_DEDUP_EN
    logic            dup_drop_reg;
`endif

    logic            ready_c;
    logic            accept_c;
    logic            clear_eff_c;
    logic            commit_c;
    logic [7:0]      avg_raw;
    logic [7:0]      avg_clamped;
    logic signed [9:0] avg_s;

    // A clear waits for a frame_start; clear and frame_start together act immediately.
    assign clear_eff_c = frame_start & (clear_pend_reg | clear);
    assign accept_c    = meas.meas_valid & ready_c;
    assign commit_c    = (state_reg == WAIT_FRAME) & frame_start & ~clear_eff_c;

    // Round half up before the shift; the accumulator has headroom for the bias.
    generate
        if (AVG_LOG2 == 0) begin : g_no_avg
            assign avg_raw = acc_reg[7:0];
        end else begin : g_avg
            logic [AW-1:0] rounded;
            assign rounded = acc_reg + AW'(1 << (AVG_LOG2 - 1));
            assign avg_raw = 8'(rounded >> AVG_LOG2);
        end
    endgenerate

    assign avg_s = $signed({2'b00, avg_raw});

    always_comb begin
        avg_clamped = avg_raw;
        if (avg_s > MAX_S) begin
            avg_clamped = MAX_S[7:0];
        end else if (avg_s < MIN_S) begin
            avg_clamped = MIN_S[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ACCUM;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ready_c    = 1'b0;
        case (state_reg)
            ACCUM: begin
                ready_c = ready_en_reg;
                if (meas.meas_valid && ready_en_reg && cnt_reg == LAST_CNT) begin
                    state_next = DIVIDE;
                end
            end
            DIVIDE: begin
                state_next = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                if (frame_start) begin
                    state_next = ACCUM;
                end
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
        if (clear_eff_c) begin
            state_next = ACCUM;
        end
    end

    assign meas.meas_ready = ready_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_reg         <= '0;
            cnt_reg         <= '0;
            avg_reg         <= '0;
            entry_count_reg <= '0;
            pending_reg     <= 1'b0;
            clear_pend_reg  <= 1'b0;
            ready_en_reg    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                hist_reg[i] <= '0;
            end
`ifdef HIST_DEDUP_EN
            dup_drop_reg    <= 1'b0;
`endif
        end else begin
            ready_en_reg <= 1'b1;
`ifdef HIST_DEDUP_EN
            dup_drop_reg <= 1'b0;
`endif
            if (clear) begin
                clear_pend_reg <= 1'b1;
            end

            if (clear_eff_c) begin
                for (int i = 0; i < DEPTH; i++) begin
                    hist_reg[i] <= '0;
                end
                entry_count_reg <= '0;
                pending_reg     <= 1'b0;
                acc_reg         <= '0;
                cnt_reg         <= '0;
                clear_pend_reg  <= 1'b0;
            end else begin
                if (accept_c) begin
                    acc_reg <= acc_reg + AW'(meas.meas_data);
                    cnt_reg <= cnt_reg + 1'b1;
                end

                if (state_reg == DIVIDE) begin
                    avg_reg     <= avg_clamped;
                    acc_reg     <= '0;
                    cnt_reg     <= '0;
                    pending_reg <= 1'b1;
                end

                if (commit_c) begin
                    pending_reg <= 1'b0;
`ifdef HIST_DEDUP_EN
                    if (entry_count_reg != 4'd0 && avg_reg == hist_reg[0]) begin
                        dup_drop_reg <= 1'b1;
                    end else begin
`else
                    begin
`endif
                        hist_reg[0] <= avg_reg;
                        for (int i = 1; i < DEPTH; i++) begin
                            hist_reg[i] <= hist_reg[i-1];
                        end
                        if (entry_count_reg < 4'(DEPTH)) begin
                            entry_count_reg <= entry_count_reg + 4'd1;
                        end
                    end
                end
            end
        end
    end

    assign hist_0      = hist_reg[0];
    assign hist_1      = hist_reg[1];
    assign hist_2      = hist_reg[2];
    assign hist_3      = hist_reg[3];
    assign hist_4      = hist_reg[4];
    assign hist_5      = hist_reg[5];
    assign hist_6      = hist_reg[6];
    assign hist_7      = hist_reg[7];
    assign hist_8      = hist_reg[8];
    assign hist_9      = hist_reg[9];
    assign entry_count = entry_count_reg;
    assign pending     = pending_reg;
`ifdef HIST_DEDUP_EN
    assign dup_drop    = dup_drop_reg;
`endif

endmodule
